// File: rtl/axi_arbiter.sv
// Arbitrates one shared AXI memory port between an instruction-fetch read master and a
// load/store master (read + write). One transaction at a time; the grant is visible on arb_owner.
module axi_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction-fetch read master
  input  logic [ADDR_WIDTH-1:0]   ifu_AR_ADDR,
  input  logic                    ifu_AR_VALID,
  output logic                    ifu_AR_READY,
  output logic [DATA_WIDTH-1:0]   ifu_R_DATA,
  output logic                    ifu_R_VALID,
  input  logic                    ifu_R_READY,
  // load/store master
  input  logic [ADDR_WIDTH-1:0]   lsu_AR_ADDR,
  input  logic                    lsu_AR_VALID,
  output logic                    lsu_AR_READY,
  output logic [DATA_WIDTH-1:0]   lsu_R_DATA,
  output logic                    lsu_R_VALID,
  input  logic                    lsu_R_READY,
  input  logic [ADDR_WIDTH-1:0]   lsu_AW_ADDR,
  input  logic                    lsu_AW_VALID,
  output logic                    lsu_AW_READY,
  input  logic [DATA_WIDTH-1:0]   lsu_W_DATA,
  input  logic [DATA_WIDTH/8-1:0] lsu_W_STRB,
  input  logic                    lsu_W_VALID,
  output logic                    lsu_W_READY,
  output logic                    lsu_B_VALID,
  input  logic                    lsu_B_READY,
  // shared memory port
  output logic [ADDR_WIDTH-1:0]   axi_AW_ADDR,
  output logic                    axi_AW_VALID,
  input  logic                    axi_AW_READY,
  output logic [DATA_WIDTH-1:0]   axi_W_DATA,
  output logic [DATA_WIDTH/8-1:0] axi_W_STRB,
  output logic                    axi_W_VALID,
  input  logic                    axi_W_READY,
  input  logic                    axi_B_VALID,
  output logic                    axi_B_READY,
  output logic [ADDR_WIDTH-1:0]   axi_AR_ADDR,
  output logic                    axi_AR_VALID,
  input  logic                    axi_AR_READY,
  input  logic [DATA_WIDTH-1:0]   axi_R_DATA,
  input  logic                    axi_R_VALID,
  output logic                    axi_R_READY,
  output logic [1:0]              arb_owner
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are both high;
  // VALID never depends on READY, and the state encoding doubles as the grant on arb_owner.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ifu_req, lsu_req;

  assign ifu_req   = ifu_AR_VALID;
  assign lsu_req   = lsu_AR_VALID | lsu_AW_VALID;
  assign arb_owner = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IFU;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ar_done_q    <= ar_done_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ar_done_d    = ar_done_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    ifu_AR_READY = 1'b0;
    ifu_R_DATA   = '0;
    ifu_R_VALID  = 1'b0;
    lsu_AR_READY = 1'b0;
    lsu_R_DATA   = '0;
    lsu_R_VALID  = 1'b0;
    lsu_AW_READY = 1'b0;
    lsu_W_READY  = 1'b0;
    lsu_B_VALID  = 1'b0;
    axi_AW_ADDR  = '0;
    axi_AW_VALID = 1'b0;
    axi_W_DATA   = '0;
    axi_W_STRB   = '0;
    axi_W_VALID  = 1'b0;
    axi_B_READY  = 1'b0;
    axi_AR_ADDR  = '0;
    axi_AR_VALID = 1'b0;
    axi_R_READY  = 1'b0;

    case (state_q)
      IDLE: begin
        // Flags are cleared here so every grant starts with a fresh one-shot.
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (lsu_req && (!ifu_req || last_grant_q == GNT_IFU)) begin
          state_d      = lsu_AW_VALID ? LSU_WR : LSU_RD;
          last_grant_d = GNT_LSU;
        end else if (ifu_req) begin
          state_d      = IFU_RD;
          last_grant_d = GNT_IFU;
        end
      end
      IFU_RD: begin
        axi_AR_ADDR  = ifu_AR_ADDR;
        axi_AR_VALID = ifu_AR_VALID & ~ar_done_q;
        ifu_AR_READY = axi_AR_READY & ~ar_done_q;
        if (ifu_AR_VALID && axi_AR_READY && !ar_done_q) ar_done_d = 1'b1;
        ifu_R_DATA   = axi_R_DATA;
        ifu_R_VALID  = axi_R_VALID;
        axi_R_READY  = ifu_R_READY;
        if (axi_R_VALID && ifu_R_READY) state_d = IDLE;
      end
      LSU_RD: begin
        axi_AR_ADDR  = lsu_AR_ADDR;
        axi_AR_VALID = lsu_AR_VALID & ~ar_done_q;
        lsu_AR_READY = axi_AR_READY & ~ar_done_q;
        if (lsu_AR_VALID && axi_AR_READY && !ar_done_q) ar_done_d = 1'b1;
        lsu_R_DATA   = axi_R_DATA;
        lsu_R_VALID  = axi_R_VALID;
        axi_R_READY  = lsu_R_READY;
        if (axi_R_VALID && lsu_R_READY) state_d = IDLE;
      end
      LSU_WR: begin
        axi_AW_ADDR  = lsu_AW_ADDR;
        axi_AW_VALID = lsu_AW_VALID & ~aw_done_q;
        lsu_AW_READY = axi_AW_READY & ~aw_done_q;
        if (lsu_AW_VALID && axi_AW_READY && !aw_done_q) aw_done_d = 1'b1;
        axi_W_DATA   = lsu_W_DATA;
        axi_W_STRB   = lsu_W_STRB;
        axi_W_VALID  = lsu_W_VALID & ~w_done_q;
        lsu_W_READY  = axi_W_READY & ~w_done_q;
        if (lsu_W_VALID && axi_W_READY && !w_done_q) w_done_d = 1'b1;
        // B ends the grant even if AW/W have not both been seen.
        lsu_B_VALID  = axi_B_VALID;
        axi_B_READY  = lsu_B_READY;
        if (axi_B_VALID && lsu_B_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Self-checking bench for axi_arbiter: directed protocol scenarios plus random traffic,
// with a scoreboard of expected read data / write beats in arbitration order.
module tb_axi_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int EW = 2 + DW/8 + DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]   ifu_AR_ADDR, lsu_AR_ADDR, lsu_AW_ADDR, axi_AW_ADDR, axi_AR_ADDR;
  logic            ifu_AR_VALID, ifu_AR_READY, ifu_R_VALID, ifu_R_READY;
  logic [DW-1:0]   ifu_R_DATA, lsu_R_DATA, lsu_W_DATA, axi_W_DATA, axi_R_DATA;
  logic            lsu_AR_VALID, lsu_AR_READY, lsu_R_VALID, lsu_R_READY;
  logic            lsu_AW_VALID, lsu_AW_READY, lsu_W_VALID, lsu_W_READY;
  logic [DW/8-1:0] lsu_W_STRB, axi_W_STRB;
  logic            lsu_B_VALID, lsu_B_READY;
  logic            axi_AW_VALID, axi_AW_READY, axi_W_VALID, axi_W_READY;
  logic            axi_B_VALID, axi_B_READY, axi_AR_VALID, axi_AR_READY;
  logic            axi_R_VALID, axi_R_READY;
  logic [1:0]      arb_owner;

  axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_AR_ADDR(ifu_AR_ADDR), .ifu_AR_VALID(ifu_AR_VALID), .ifu_AR_READY(ifu_AR_READY),
    .ifu_R_DATA(ifu_R_DATA), .ifu_R_VALID(ifu_R_VALID), .ifu_R_READY(ifu_R_READY),
    .lsu_AR_ADDR(lsu_AR_ADDR), .lsu_AR_VALID(lsu_AR_VALID), .lsu_AR_READY(lsu_AR_READY),
    .lsu_R_DATA(lsu_R_DATA), .lsu_R_VALID(lsu_R_VALID), .lsu_R_READY(lsu_R_READY),
    .lsu_AW_ADDR(lsu_AW_ADDR), .lsu_AW_VALID(lsu_AW_VALID), .lsu_AW_READY(lsu_AW_READY),
    .lsu_W_DATA(lsu_W_DATA), .lsu_W_STRB(lsu_W_STRB), .lsu_W_VALID(lsu_W_VALID),
    .lsu_W_READY(lsu_W_READY), .lsu_B_VALID(lsu_B_VALID), .lsu_B_READY(lsu_B_READY),
    .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID), .axi_AW_READY(axi_AW_READY),
    .axi_W_DATA(axi_W_DATA), .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID),
    .axi_W_READY(axi_W_READY), .axi_B_VALID(axi_B_VALID), .axi_B_READY(axi_B_READY),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY),
    .arb_owner(arb_owner)
  );

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [1:0]    own_q[$];
  bit   slave_auto = 1'b0;
  bit   mon_en = 1'b0;
  bit   aw_seen, w_seen;
  logic model_last;  // 0 = IFU granted last, 1 = LSU
  int   aw_cnt, w_cnt;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h13;
    return {a[31:0] ^ 32'hdead_beef, a[31:0]};
  endfunction

  function automatic logic [11:0] all_vr();
    return {ifu_AR_READY, ifu_R_VALID, lsu_AR_READY, lsu_R_VALID, lsu_AW_READY, lsu_W_READY,
            lsu_B_VALID, axi_AW_VALID, axi_W_VALID, axi_B_READY, axi_AR_VALID, axi_R_READY};
  endfunction

  // Anything that must be quiet for the current owner.
  function automatic logic [15:0] leak();
    logic [15:0] l = '0;
    if (arb_owner != 2'd1) l[1:0] = {ifu_AR_READY, ifu_R_VALID};
    if (arb_owner != 2'd2) l[3:2] = {lsu_AR_READY, lsu_R_VALID};
    if (arb_owner != 2'd3)
      l[12:4] = {lsu_AW_READY, lsu_W_READY, lsu_B_VALID, axi_AW_VALID, axi_W_VALID, axi_B_READY,
                 axi_AW_ADDR != 0, axi_W_DATA != 0, axi_W_STRB != 0};
    if (arb_owner == 2'd0 || arb_owner == 2'd3)
      l[15:13] = {axi_AR_VALID, axi_R_READY, axi_AR_ADDR != 0};
    return l;
  endfunction

  task automatic sb_pop(input string tag, input logic [EW-1:0] got);
    check({tag, "_pending"}, EW'(exp_q.size() > 0), EW'(1));
    if (exp_q.size() > 0) check(tag, got, exp_q.pop_front());
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (ifu_R_VALID && ifu_R_READY) sb_pop("ifu_r", {2'd1, 8'h00, ifu_R_DATA});
      if (lsu_R_VALID && lsu_R_READY) sb_pop("lsu_r", {2'd2, 8'h00, lsu_R_DATA});
      if (axi_W_VALID && axi_W_READY) begin
        w_cnt++;
        sb_pop("axi_w", {2'd3, axi_W_STRB, axi_W_DATA});
      end
      if (axi_AW_VALID && axi_AW_READY) aw_cnt++;
      check("isolation", EW'(leak()), '0);
    end
  end

  // responsive memory slave, active only when slave_auto is set
  initial begin
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [AW-1:0] ar_a;
    forever begin
      @(negedge clk);
      ar_hs = axi_AR_VALID && axi_AR_READY;
      ar_a  = axi_AR_ADDR;
      r_hs  = axi_R_VALID && axi_R_READY;
      aw_hs = axi_AW_VALID && axi_AW_READY;
      w_hs  = axi_W_VALID && axi_W_READY;
      b_hs  = axi_B_VALID && axi_B_READY;
      @(posedge clk); #1;
      if (slave_auto) begin
        axi_AR_READY = 1'b1; axi_AW_READY = 1'b1; axi_W_READY = 1'b1;
        if (r_hs) begin axi_R_VALID = 1'b0; axi_R_DATA = '0; end
        if (ar_hs) begin axi_R_VALID = 1'b1; axi_R_DATA = model_rdata(ar_a); end
        if (b_hs) axi_B_VALID = 1'b0;
        if (aw_hs) aw_seen = 1'b1;
        if (w_hs) w_seen = 1'b1;
        if (aw_seen && w_seen && !axi_B_VALID) begin
          axi_B_VALID = 1'b1; aw_seen = 1'b0; w_seen = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_auto(input bit on);
    slave_auto = on;
    axi_AR_READY = 0; axi_AW_READY = 0; axi_W_READY = 0;
    axi_R_VALID = 0; axi_R_DATA = '0; axi_B_VALID = 0;
    aw_seen = 0; w_seen = 0;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0; model_last = 1'b0;
  endtask

  task automatic ifu_read(input logic [AW-1:0] a);
    bit got = 0;
    ifu_AR_ADDR = a; ifu_AR_VALID = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); got = ifu_AR_READY; cyc();
    end
    ifu_AR_VALID = 1'b0; ifu_AR_ADDR = '0;
    check("ifu_ar_timeout", EW'(got), EW'(1));
  endtask

  task automatic lsu_read(input logic [AW-1:0] a);
    bit got = 0;
    lsu_AR_ADDR = a; lsu_AR_VALID = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); got = lsu_AR_READY; cyc();
    end
    lsu_AR_VALID = 1'b0; lsu_AR_ADDR = '0;
    check("lsu_ar_timeout", EW'(got), EW'(1));
  endtask

  task automatic lsu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] s);
    bit aw_ok = 0, w_ok = 0, aw_now, w_now;
    lsu_AW_ADDR = a; lsu_AW_VALID = 1'b1;
    lsu_W_DATA = d; lsu_W_STRB = s; lsu_W_VALID = 1'b1;
    for (int i = 0; i < 40 && !(aw_ok && w_ok); i++) begin
      @(negedge clk);
      aw_now = lsu_AW_VALID && lsu_AW_READY;
      w_now  = lsu_W_VALID && lsu_W_READY;
      cyc();
      if (aw_now) begin aw_ok = 1; lsu_AW_VALID = 0; lsu_AW_ADDR = '0; end
      if (w_now) begin w_ok = 1; lsu_W_VALID = 0; lsu_W_DATA = '0; lsu_W_STRB = '0; end
    end
    check("lsu_wr_timeout", EW'(aw_ok && w_ok), EW'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (arb_owner != 2'd0 && n < 40);
    check("idle_timeout", EW'(arb_owner), EW'(0));
    cyc();
  endtask

  task automatic check_owners();
    while (own_q.size() > 0) begin
      @(negedge clk);
      check("owner_seq", EW'(arb_owner), EW'(own_q.pop_front()));
    end
  endtask

  // Tie between IFU and LSU reads; the model decides the winner from the last grant.
  task automatic tie_read(input logic [AW-1:0] ai, input logic [AW-1:0] al, input bit with_seq);
    if (model_last == 1'b0) begin
      exp_q.push_back({2'd2, 8'h00, model_rdata(al)});
      exp_q.push_back({2'd1, 8'h00, model_rdata(ai)});
      if (with_seq) own_q = {2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
      model_last = 1'b0;
    end else begin
      exp_q.push_back({2'd1, 8'h00, model_rdata(ai)});
      exp_q.push_back({2'd2, 8'h00, model_rdata(al)});
      if (with_seq) own_q = {2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0};
      model_last = 1'b1;
    end
    fork
      ifu_read(ai);
      lsu_read(al);
      check_owners();
    join
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a, a2;
    logic [DW-1:0] d;
    logic [7:0] s;
    rst = 1'b1;
    ifu_AR_ADDR = '0; ifu_AR_VALID = 0; ifu_R_READY = 1;
    lsu_AR_ADDR = '0; lsu_AR_VALID = 0; lsu_R_READY = 1;
    lsu_AW_ADDR = '0; lsu_AW_VALID = 0; lsu_W_DATA = '0; lsu_W_STRB = '0;
    lsu_W_VALID = 0; lsu_B_READY = 1;
    model_last = 1'b0;
    set_auto(1'b0);
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_owner", EW'(arb_owner), EW'(0));
    check("rst_valid_ready", EW'(all_vr()), EW'(0));
    mon_en = 1'b1;

    // single IFU fetch with a one-cycle memory
    set_auto(1'b1);
    exp_q.push_back({2'd1, 8'h00, 64'h13});
    ifu_AR_ADDR = 64'h8000_0000; ifu_AR_VALID = 1'b1;
    @(negedge clk);
    check("fetch_owner_c0", EW'(arb_owner), EW'(0));
    check("fetch_arvalid_c0", EW'(axi_AR_VALID), EW'(0));
    cyc(); @(negedge clk);
    check("fetch_owner_c1", EW'(arb_owner), EW'(1));
    check("fetch_araddr_c1", EW'(axi_AR_ADDR), EW'(64'h8000_0000));
    check("fetch_arvalid_c1", EW'(axi_AR_VALID), EW'(1));
    cyc(); ifu_AR_VALID = 1'b0; ifu_AR_ADDR = '0;
    @(negedge clk);
    check("fetch_owner_c2", EW'(arb_owner), EW'(1));
    check("fetch_rdata", EW'(ifu_R_DATA), EW'(64'h13));
    cyc(); @(negedge clk);
    check("fetch_owner_c3", EW'(arb_owner), EW'(0));
    cyc();

    // ties after reset: LSU, LSU again (IFU was last), then IFU after a lone LSU grant
    do_reset();
    tie_read(64'h1000, 64'h2000, 1'b1);
    tie_read(64'h1100, 64'h2100, 1'b1);
    exp_q.push_back({2'd2, 8'h00, model_rdata(64'h2200)});
    lsu_read(64'h2200); model_last = 1'b1;
    wait_idle();
    tie_read(64'h1300, 64'h2300, 1'b1);

    // write with W completing before AW; both sides keep VALID/READY high afterwards
    set_auto(1'b0);
    exp_q.push_back({2'd3, 8'h0f, 64'h0123_4567_89ab_cdef});
    aw_cnt = 0; w_cnt = 0;
    lsu_AW_ADDR = 64'h3000; lsu_AW_VALID = 1;
    lsu_W_DATA = 64'h0123_4567_89ab_cdef; lsu_W_STRB = 8'h0f; lsu_W_VALID = 1;
    @(negedge clk); check("wr_owner_c0", EW'(arb_owner), EW'(0));
    cyc(); @(negedge clk);
    check("wr_owner_c1", EW'(arb_owner), EW'(3));
    check("wr_valids_c1", EW'({axi_AW_VALID, axi_W_VALID}), EW'(2'b11));
    cyc(); axi_W_READY = 1; @(negedge clk);
    check("wr_wready_c2", EW'(lsu_W_READY), EW'(1));
    cyc(); @(negedge clk);
    check("wr_wvalid_c3", EW'(axi_W_VALID), EW'(0));
    check("wr_wready_c3", EW'(lsu_W_READY), EW'(0));
    cyc(); axi_AW_READY = 1; @(negedge clk);
    check("wr_awvalid_c4", EW'(axi_AW_VALID), EW'(1));
    cyc(); @(negedge clk);
    check("wr_awvalid_c5", EW'(axi_AW_VALID), EW'(0));
    check("wr_owner_c5", EW'(arb_owner), EW'(3));
    cyc(); axi_B_VALID = 1; @(negedge clk);
    check("wr_bvalid_c6", EW'({lsu_B_VALID, axi_B_READY}), EW'(2'b11));
    cyc();
    axi_B_VALID = 0; axi_AW_READY = 0; axi_W_READY = 0;
    lsu_AW_VALID = 0; lsu_W_VALID = 0; lsu_AW_ADDR = '0; lsu_W_DATA = '0; lsu_W_STRB = '0;
    @(negedge clk);
    check("wr_owner_c7", EW'(arb_owner), EW'(0));
    check("wr_aw_count", EW'(aw_cnt), EW'(1));
    check("wr_w_count", EW'(w_cnt), EW'(1));
    cyc();

    // B arriving before AW completes still ends the grant
    exp_q.push_back({2'd3, 8'hf0, 64'h55});
    lsu_AW_ADDR = 64'h3100; lsu_AW_VALID = 1;
    lsu_W_DATA = 64'h55; lsu_W_STRB = 8'hf0; lsu_W_VALID = 1;
    cyc(); axi_W_READY = 1; axi_B_VALID = 1;
    @(negedge clk);
    check("early_b_owner", EW'(arb_owner), EW'(3));
    check("early_b_fwd", EW'(lsu_B_VALID), EW'(1));
    cyc();
    axi_W_READY = 0; axi_B_VALID = 0;
    lsu_AW_VALID = 0; lsu_W_VALID = 0; lsu_AW_ADDR = '0; lsu_W_DATA = '0; lsu_W_STRB = '0;
    @(negedge clk);
    check("early_b_idle", EW'(arb_owner), EW'(0));
    cyc();
    model_last = 1'b1;

    // spurious responses while idle
    axi_R_VALID = 1; axi_R_DATA = 64'hbad; axi_B_VALID = 1;
    @(negedge clk);
    check("spur_rready", EW'(axi_R_READY), EW'(0));
    check("spur_rvalid_fwd", EW'({ifu_R_VALID, lsu_R_VALID}), EW'(0));
    check("spur_b", EW'({axi_B_READY, lsu_B_VALID}), EW'(0));
    cyc(); axi_R_VALID = 0; axi_R_DATA = '0; axi_B_VALID = 0;

    // IFU drops VALID before its AR handshake: grant is held
    exp_q.push_back({2'd1, 8'h00, model_rdata(64'h4000)});
    ifu_AR_ADDR = 64'h4000; ifu_AR_VALID = 1;
    cyc(); @(negedge clk);
    check("drop_owner_c1", EW'(arb_owner), EW'(1));
    cyc(); ifu_AR_VALID = 0; @(negedge clk);
    check("drop_owner_c2", EW'(arb_owner), EW'(1));
    check("drop_arvalid_c2", EW'(axi_AR_VALID), EW'(0));
    cyc(); ifu_AR_VALID = 1; axi_AR_READY = 1; @(negedge clk);
    check("drop_arvalid_c3", EW'(axi_AR_VALID), EW'(1));
    cyc(); axi_AR_READY = 0; axi_R_VALID = 1; axi_R_DATA = model_rdata(64'h4000);
    @(negedge clk);
    check("drop_ar_once", EW'(axi_AR_VALID), EW'(0));
    cyc(); ifu_AR_VALID = 0; ifu_AR_ADDR = '0; axi_R_VALID = 0; axi_R_DATA = '0;
    @(negedge clk);
    check("drop_idle", EW'(arb_owner), EW'(0));
    cyc();
    model_last = 1'b0;

    // reset in the cycle after the AR handshake
    ifu_AR_ADDR = 64'h5000; ifu_AR_VALID = 1;
    cyc(); axi_AR_READY = 1;
    cyc(); axi_AR_READY = 0; ifu_AR_VALID = 0; ifu_AR_ADDR = '0; rst = 1;
    cyc(); rst = 0; model_last = 1'b0;
    @(negedge clk);
    check("rstmid_owner", EW'(arb_owner), EW'(0));
    check("rstmid_valid_ready", EW'(all_vr()), EW'(0));
    set_auto(1'b1);
    exp_q.push_back({2'd1, 8'h00, model_rdata(64'h5040)});
    ifu_read(64'h5040); model_last = 1'b0;
    wait_idle();

    // random traffic against the responsive slave
    for (int i = 0; i < 40; i++) begin
      a  = {32'h0, $urandom} & 64'hffff_fff8;
      a2 = {32'h0, $urandom} & 64'hffff_fff8;
      case ($urandom_range(0, 3))
        0: begin
          exp_q.push_back({2'd1, 8'h00, model_rdata(a)});
          ifu_read(a); model_last = 1'b0; wait_idle();
        end
        1: begin
          exp_q.push_back({2'd2, 8'h00, model_rdata(a)});
          lsu_read(a); model_last = 1'b1; wait_idle();
        end
        2: begin
          d = {$urandom, $urandom};
          s = 8'($urandom_range(1, 255));
          exp_q.push_back({2'd3, s, d});
          lsu_write(a, d, s); model_last = 1'b1; wait_idle();
        end
        default: tie_read(a, a2, 1'b0);
      endcase
    end

    repeat (3) cyc();
    check("sb_drain", EW'(exp_q.size()), EW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
